// File: rtl/uart_pkg.sv
// uart_pkg: parity mode constants and receiver FSM state encodings shared by the UART receive path.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with occupancy count; simultaneous push and pop allowed when full.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Wr_En,
  input  logic [WIDTH-1:0]             i_Wr_Data,
  input  logic                         i_Rd_En,
  output logic [WIDTH-1:0]             o_Rd_Data,
  output logic                         o_Empty,
  output logic                         o_Full,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  assign o_Empty = r_count == '0;
  assign o_Full = r_count == CW'(DEPTH);
  assign o_Count = r_count;
  assign w_pop = i_Rd_En && !o_Empty;
  assign w_push = i_Wr_En && (!o_Full || w_pop);
  // Head is forced to zero when empty so stale memory never reaches the outputs.
  assign o_Rd_Data = o_Empty ? '0 : r_mem[r_rd];
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge i_Clock)
    if (w_push) r_mem[r_wr] <= i_Wr_Data;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with majority-vote sampling, runtime parity, break handling
// and a small receive FIFO with sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset,
  input  logic                              i_Rx_Serial,
  input  logic [1:0]                        i_Parity_Mode,
  input  logic                              i_Rd_En,
  input  logic                              i_Clr_Overrun,
  output logic [DATA_BITS-1:0]              o_Rx_Byte,
  output logic                              o_Parity_Err,
  output logic                              o_Frame_Err,
  output logic                              o_Rx_Valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count,
  output logic                              o_Overrun,
  output logic                              o_Rx_Active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  logic [1:0] r_sync;
  logic [2:0] r_hist;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic [1:0] r_mode;
  logic r_perr, r_ferr, r_overrun;
  logic w_vote, w_centre, w_tick, w_push, w_full, w_empty, w_par_err, w_has_par;
  logic [DATA_BITS+1:0] w_head;
  assign w_vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_centre = r_cnt == CW'(CLKS_PER_BIT-1);
  assign w_tick = (r_state == S_START) ? r_cnt == CW'(CLKS_PER_BIT/2) : w_centre;
  assign w_push = r_state == S_STOP && w_centre && r_idx == IW'(STOP_BITS-1);
  assign w_has_par = r_mode == PAR_EVEN || r_mode == PAR_ODD;
  assign w_par_err = ^r_data ^ w_vote ^ (r_mode == PAR_ODD);
  assign {o_Frame_Err, o_Parity_Err, o_Rx_Byte} = w_head;
  assign o_Rx_Valid = !w_empty;
  assign o_Overrun = r_overrun;
  assign o_Rx_Active = r_state != S_IDLE;
  uart_sync_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Wr_En(w_push), .i_Wr_Data({r_ferr | ~w_vote, r_perr, r_data}),
    .i_Rd_En(i_Rd_En), .o_Rd_Data(w_head),
    .o_Empty(w_empty), .o_Full(w_full), .o_Count(o_Fifo_Count)
  );
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_sync <= 2'b11;
      r_hist <= 3'b111;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_mode <= PAR_NONE;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_Rx_Serial};
      r_hist <= {r_hist[1:0], r_sync[1]};
      r_overrun <= (w_push && w_full && !i_Rd_En) | (r_overrun & ~i_Clr_Overrun);
      r_cnt <= (r_state == S_IDLE || r_state == S_BREAK || w_tick) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE:
          if (!r_sync[1]) begin
            r_state <= S_START;
            r_mode <= i_Parity_Mode;
            r_idx <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
          end
        S_START: if (w_tick) r_state <= w_vote ? S_IDLE : S_DATA;
        S_DATA:
          if (w_centre) begin
            r_data[r_idx] <= w_vote;
            r_idx <= (r_idx == IW'(DATA_BITS-1)) ? '0 : r_idx + 1'b1;
            r_state <= (r_idx != IW'(DATA_BITS-1)) ? S_DATA : w_has_par ? S_PARITY : S_STOP;
          end
        S_PARITY:
          if (w_centre) begin
            r_perr <= w_par_err;
            r_state <= S_STOP;
          end
        S_STOP:
          if (w_centre) begin
            r_ferr <= r_ferr | ~w_vote;
            r_idx <= w_push ? '0 : r_idx + 1'b1;
            r_state <= !w_push ? S_STOP : w_vote ? S_IDLE : S_BREAK;
          end
        default: if (r_sync[1]) r_state <= S_IDLE;
      endcase
    end
endmodule
